// File: rtl/flick_conditioner.sv
// Turns the raw, bouncing, asynchronous flick button into a clean flick request.
// The request is held until the flasher's slow tick consumes it.
module flick_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       tick,
  output logic       flick,
  output logic       flick_level,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // btn_raw lands directly in the first flop; nothing combinational ahead of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STABLE_LO;
      cnt         <= '0;
      flick_level <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= 8'd0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HI: begin
          // Any bounce back discards all accumulated progress.
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= STABLE_HI;
            cnt         <= '0;
            flick_level <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= STABLE_LO;
            cnt         <= '0;
            flick_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A new press in the same cycle as a tick wins, so it survives for the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flick <= 1'b0;
    end else if (press_pulse) begin
      flick <= 1'b1;
    end else if (tick && flick) begin
      flick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench for flick_conditioner with a short debounce window.
module tb_flick_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       tick;
  logic       flick;
  logic       flick_level;
  logic       press_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  flick_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .tick(tick),
    .flick(flick),
    .flick_level(flick_level),
    .press_pulse(press_pulse),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting press pulses and noting the first edge (1-based) with one.
  task automatic run(input int n, output int np, output int first);
    np = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (press_pulse) begin
        np++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int   np;
    int   first;
    int   tot;
    int   bad;
    logic lvl10;
    logic bseq [14];

    // Reset with the button already held
    rst = 1'b1; btn_raw = 1'b1; tick = 1'b0;
    step(); step();
    chk1("rst_flick", flick, 1'b0);
    chk1("rst_level", flick_level, 1'b0);
    chk1("rst_pulse", press_pulse, 1'b0);
    chk8("rst_count", press_count, 8'd0);
    rst = 1'b0;
    run(5, np, first);
    chki("t1_no_early_pulse", np, 0);
    chk1("t1_level_early", flick_level, 1'b0);
    step();
    chk1("t1_pulse", press_pulse, 1'b1);
    chk1("t1_level", flick_level, 1'b1);
    chk8("t1_count", press_count, 8'd1);
    step();
    chk1("t1_pulse_one_cycle", press_pulse, 1'b0);
    chk1("t1_flick_set", flick, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    chk1("t1_flick_consumed", flick, 1'b0);

    // Clean release and press
    btn_raw = 1'b0;
    run(5, np, first);
    chk1("t2_level_hold", flick_level, 1'b1);
    step();
    chk1("t2_level_low", flick_level, 1'b0);
    chk1("t2_no_release_pulse", press_pulse, 1'b0);
    chki("t2_release_pulses", np, 0);
    btn_raw = 1'b1;
    run(10, np, first);
    chki("t2_press_pulses", np, 1);
    chki("t2_press_latency", first, 6);
    chk8("t2_count", press_count, 8'd2);
    chk1("t2_flick", flick, 1'b1);

    // Flick held across a long tick-free interval, then consumed
    run(17, np, first);
    chk1("t4_flick_held", flick, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    chk1("t4_flick_cleared", flick, 1'b0);
    step();
    chk1("t4_flick_stays_clear", flick, 1'b0);
    btn_raw = 1'b0;
    run(8, np, first);
    chki("t4_release_pulses", np, 0);
    chk1("t4_level_low", flick_level, 1'b0);

    // Bounce: only the final run of four highs counts
    bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    np = 0; first = 0; lvl10 = 1'bx;
    for (int i = 1; i <= 14; i++) begin
      btn_raw = bseq[i-1];
      step();
      if (press_pulse) begin
        np++;
        if (first == 0) first = i;
      end
      if (i == 10) lvl10 = flick_level;
    end
    chki("t3_bounce_pulses", np, 1);
    chki("t3_bounce_latency", first, 11);
    chk1("t3_level_before_commit", lvl10, 1'b0);
    chk8("t3_count", press_count, 8'd3);
    btn_raw = 1'b0;
    run(8, np, first);
    chk1("t3_flick_pending", flick, 1'b1);

    // Press pulse coinciding with tick keeps flick set
    btn_raw = 1'b1;
    run(5, np, first);
    chki("t4b_no_early_pulse", np, 0);
    step();
    chk1("t4b_pulse", press_pulse, 1'b1);
    chk8("t4b_count", press_count, 8'd4);
    tick = 1'b1; step(); tick = 1'b0;
    chk1("t4b_set_wins", flick, 1'b1);
    run(3, np, first);
    chk1("t4b_flick_until_tick", flick, 1'b1);
    tick = 1'b1; step(); tick = 1'b0;
    chk1("t4b_flick_next_tick", flick, 1'b0);
    btn_raw = 1'b0;
    run(8, np, first);

    // Three-cycle glitch is one short of acceptance
    btn_raw = 1'b1;
    run(3, np, first);
    tot = np;
    btn_raw = 1'b0;
    run(8, np, first);
    tot += np;
    chki("t3_glitch_pulses", tot, 0);
    chk1("t3_glitch_level", flick_level, 1'b0);
    chk8("t3_glitch_count", press_count, 8'd4);

    // Count wrap, two presses per tick window
    tot = 0; bad = 0;
    for (int p = 0; p < 125; p++) begin
      for (int k = 0; k < 2; k++) begin
        btn_raw = 1'b1; run(7, np, first); tot += np;
        btn_raw = 1'b0; run(7, np, first); tot += np;
      end
      if (flick !== 1'b1) bad++;
      tick = 1'b1; step(); tick = 1'b0;
      run(2, np, first); tot += np;
      if (flick !== 1'b0) bad++;
    end
    chki("t5_pulses", tot, 250);
    chki("t5_flick_windows", bad, 0);
    chk8("t5_count_fe", press_count, 8'hFE);
    btn_raw = 1'b1; run(7, np, first);
    btn_raw = 1'b0; run(7, np, first);
    chk8("t5_count_ff", press_count, 8'hFF);
    btn_raw = 1'b1; run(7, np, first);
    btn_raw = 1'b0; run(7, np, first);
    chk8("t5_count_wrap", press_count, 8'h00);
    tick = 1'b1; step(); tick = 1'b0;

    // Async reset mid-debounce with flick pending
    btn_raw = 1'b1; run(7, np, first);
    btn_raw = 1'b0; run(7, np, first);
    btn_raw = 1'b1; run(4, np, first);
    chk1("t6_flick_pending", flick, 1'b1);
    chk8("t6_count_pre", press_count, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk1("t6_async_flick", flick, 1'b0);
    chk8("t6_async_count", press_count, 8'd0);
    chk1("t6_async_level", flick_level, 1'b0);
    chk1("t6_async_pulse", press_pulse, 1'b0);
    step(); step();
    rst = 1'b0;
    run(5, np, first);
    chki("t6_redebounce_early", np, 0);
    step();
    chk1("t6_redebounce_pulse", press_pulse, 1'b1);
    chk8("t6_redebounce_count", press_count, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
